i2c_byte_ctrl: RTL and testbench

Byte-level I2C master sequencer. It drives the open-drain control inputs of the I2C bus interface (SCL_out/SDA_out, where 1 = release and 0 = pull low) and reads the bus back through SCL_in/SDA_in. A host issues one command at a time: START, STOP, WRITE byte or READ byte. The block generates quarter-bit timing, samples ACK/data, detects arbitration loss and, optionally, honours slave clock stretching.

---
 rtl/i2c_byte_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_ctrl.sv
// rtl/i2c_byte_ctrl.sv - byte-level I2C master sequencer (START/STOP/WRITE/READ)
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_byte_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_nack,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ack_rx,
    output logic       arb_lost,
    output logic       SCL_out,
    output logic       SDA_out,
    input  logic       SCL_in,
    input  logic       SDA_in
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_ABORT} state_t;

    localparam logic [15:0] QTR_LAST = 16'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [1:0]  qtr, qtr_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  bit_idx, bit_n;
    logic        rd_dir, rd_dir_n;
    logic [7:0]  wdata, wdata_n;
    logic        nack, nack_n;
    logic [7:0]  rdata_n;
    logic        ack_n, arb_n, done_n, scl_n, sda_n;
    logic [1:0]  sda_sync;
    logic        sda_s, hold, qtr_end, sample;

    assign sda_s     = sda_sync[1];
    assign cmd_ready = (state == S_IDLE);

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync;

    always_ff @(posedge clk) begin
        if (rst) scl_sync <= 2'b11;
        else     scl_sync <= {scl_sync[0], SCL_in};
    end

    // Quarter B always has SCL released; wait for the bus to actually go high.
    assign hold = (qtr == 2'd1) && !scl_sync[1] &&
                  (state == S_START || state == S_STOP || state == S_BIT);
`else
    logic unused_scl_in;
    assign unused_scl_in = SCL_in;
    assign hold          = 1'b0;
`endif

    assign qtr_end = (cnt == 16'd0) && !hold;
    assign sample  = (qtr == 2'd2) && (cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            qtr      <= 2'd0;
            cnt      <= 16'd0;
            bit_idx  <= 4'd0;
            rd_dir   <= 1'b0;
            wdata    <= 8'h00;
            nack     <= 1'b0;
            rdata    <= 8'h00;
            ack_rx   <= 1'b1;
            arb_lost <= 1'b0;
            done     <= 1'b0;
            SCL_out  <= 1'b1;
            SDA_out  <= 1'b1;
            sda_sync <= 2'b11;
        end else begin
            state    <= state_n;
            qtr      <= qtr_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            rd_dir   <= rd_dir_n;
            wdata    <= wdata_n;
            nack     <= nack_n;
            rdata    <= rdata_n;
            ack_rx   <= ack_n;
            arb_lost <= arb_n;
            done     <= done_n;
            SCL_out  <= scl_n;
            SDA_out  <= sda_n;
            sda_sync <= {sda_sync[0], SDA_in};
        end
    end

    always_comb begin
        state_n  = state;
        qtr_n    = qtr;
        cnt_n    = cnt;
        bit_n    = bit_idx;
        rd_dir_n = rd_dir;
        wdata_n  = wdata;
        nack_n   = nack;
        rdata_n  = rdata;
        ack_n    = ack_rx;
        arb_n    = arb_lost;
        done_n   = 1'b0;
        scl_n    = SCL_out;
        sda_n    = SDA_out;

        if (!hold && cnt != 16'd0) cnt_n = cnt - 16'd1;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    rdata_n  = 8'h00;
                    ack_n    = 1'b0;
                    arb_n    = 1'b0;
                    wdata_n  = cmd_wdata;
                    nack_n   = cmd_nack;
                    qtr_n    = 2'd0;
                    cnt_n    = QTR_LAST;
                    bit_n    = 4'd0;
                    rd_dir_n = cmd_op[0];
                    case (cmd_op)
                        2'b00:   state_n = S_START;
                        2'b01:   state_n = S_STOP;
                        default: state_n = S_BIT;
                    endcase
                end
            end
            S_START, S_STOP: begin
                if (state == S_START && qtr == 2'd1 && qtr_end && !sda_s) begin
                    arb_n   = 1'b1;
                    state_n = S_ABORT;
                end else if (qtr_end) begin
                    cnt_n = QTR_LAST;
                    if (qtr == 2'd3) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        qtr_n = qtr + 2'd1;
                    end
                end
            end
            S_BIT: begin
                // Another master pulled SDA low while we released it for a data bit.
                if (sample && !rd_dir && bit_idx != 4'd8 && wdata[~bit_idx[2:0]] && !sda_s) begin
                    arb_n   = 1'b1;
                    state_n = S_ABORT;
                end else begin
                    if (sample) begin
                        if (bit_idx == 4'd8) begin
                            if (!rd_dir) ack_n = sda_s;
                        end else if (rd_dir) begin
                            rdata_n = {rdata[6:0], sda_s};
                        end
                    end
                    if (qtr_end) begin
                        cnt_n = QTR_LAST;
                        if (qtr != 2'd3) begin
                            qtr_n = qtr + 2'd1;
                        end else if (bit_idx != 4'd8) begin
                            qtr_n = 2'd0;
                            bit_n = bit_idx + 4'd1;
                        end else begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            S_ABORT: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Lines are registered from the next step; IDLE keeps the bus as the last step left it.
        case (state_n)
            S_START: begin
                scl_n = qtr_n[0] ^ qtr_n[1];
                sda_n = !qtr_n[1];
            end
            S_STOP: begin
                scl_n = (qtr_n != 2'd0);
                sda_n = qtr_n[1];
            end
            S_BIT: begin
                scl_n = qtr_n[0] ^ qtr_n[1];
                if (bit_n == 4'd8) sda_n = rd_dir_n ? nack_n : 1'b1;
                else               sda_n = rd_dir_n | wdata_n[~bit_n[2:0]];
            end
            S_ABORT: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb/tb_i2c_byte_ctrl.sv - self-checking bench for i2c_byte_ctrl
// Cycle-level bus model with an open-drain slave; expectations come from a quarter-sequence model.
module tb_i2c_byte_ctrl;
    localparam int K = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif
    localparam int LAT_SS   = 1 + 4 * K + SX;
    localparam int LAT_WR   = 1 + 36 * K + 9 * SX;
    localparam int LAT_ARBS = 2 * K + SX + 2;
    localparam int LAT_ARBW = 11 * K + 3 * SX + 2;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_nack, done, ack_rx, arb_lost;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata, rdata;
    logic       SCL_out, SDA_out, SCL_in, SDA_in;
    logic       slave_sda = 1'b1;
    logic       slave_scl = 1'b1;

    assign SDA_in = SDA_out & slave_sda;
    assign SCL_in = SCL_out & slave_scl;

    always #5 clk = ~clk;

    i2c_byte_ctrl #(.CLK_DIV(K)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack), .done(done),
        .rdata(rdata), .ack_rx(ack_rx), .arb_lost(arb_lost), .SCL_out(SCL_out),
        .SDA_out(SDA_out), .SCL_in(SCL_in), .SDA_in(SDA_in)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] wd;
        logic       nack;
        logic [7:0] sb;
        logic       sack;
        int         ext_q;
        int         exp_len;
        logic [7:0] exp_rdata;
        logic       exp_ack;
        logic       exp_arb;
    } vec_t;

    vec_t tbl [8];
    int   errors = 0;
    int   checks = 0;

    bit m_scl [0:1023];
    bit m_sda [0:1023];
    bit m_ssda [0:1023];
    bit m_sscl [0:1023];
    int m_len;
    bit m_arb;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, id, act, exp);
        end
    endtask

    // Expected line levels and slave drive per cycle after accept (index 1 = first cycle of quarter A).
    task automatic build_model(input logic [1:0] op, input logic [7:0] wd, input logic nack,
                               input logic [7:0] sb, input logic sack, input int ext_q, input int hold);
        int n = 1;
        int nq = op[1] ? 36 : 4;
        bit sda = 1'b1;
        bit scl = 1'b1;
        m_arb = 1'b0;
        for (int q = 0; q < nq; q++) begin
            int  b   = q / 4;
            int  qq  = q % 4;
            int  len = K;
            bit  ssda = 1'b1;
            scl = (qq == 1 || qq == 2);
            if (op == 2'd0)      sda = (qq < 2);
            else if (op == 2'd1) begin sda = (qq >= 2); scl = (qq != 0); end
            else if (b == 8)     sda = op[0] ? nack : 1'b1;
            else                 sda = op[0] ? 1'b1 : wd[3'(7 - b)];
            if (op == 2'd2 && b == 8) ssda = sack;
            if (op == 2'd3 && b < 8)  ssda = sb[3'(7 - b)];
            if (q == ext_q)           ssda = 1'b0;
            if (SX != 0 && qq == 1) len = len + SX + ((q == 1) ? hold : 0);
            for (int c = 0; c < len; c++) begin
                m_scl[n]  = scl;
                m_sda[n]  = sda;
                m_ssda[n] = ssda;
                m_sscl[n] = !(q == 1 && c < hold);
                n++;
            end
            if (q == ext_q && sda && ((op == 2'd0 && qq == 1) || (op == 2'd2 && b < 8 && qq == 2))) begin
                m_arb     = 1'b1;
                m_scl[n]  = 1'b1;
                m_sda[n]  = 1'b1;
                m_ssda[n] = 1'b1;
                m_sscl[n] = 1'b1;
                n++;
                break;
            end
        end
        m_len        = n;
        m_scl[n]     = m_arb ? 1'b1 : scl;
        m_sda[n]     = m_arb ? 1'b1 : sda;
        m_ssda[n]    = 1'b1;
        m_sscl[n]    = 1'b1;
    endtask

    // Entered and left at a negedge; returns in the done cycle so the next call is back-to-back.
    task automatic run_cmd(input int id, input logic [1:0] op, input logic [7:0] wd, input logic nack,
                           input int exp_len, input logic [7:0] exp_rdata, input logic exp_ack,
                           input logic exp_arb);
        int         got = 0;
        int         bad_n = 0;
        int         busy_n = 0;
        logic [1:0] bad_got = 2'b00;
        logic [1:0] bad_exp = 2'b00;
        chk("ready_before_accept", id, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        cmd_nack  = nack;
        @(posedge clk);
        for (int n = 1; n <= m_len + 20 && got == 0; n++) begin
            @(negedge clk);
            slave_sda = (n <= m_len) ? m_ssda[n] : 1'b1;
            slave_scl = (n <= m_len) ? m_sscl[n] : 1'b1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_wdata = 8'($urandom);
            cmd_nack  = 1'($urandom_range(0, 1));
            if (n <= m_len && bad_n == 0 && {SCL_out, SDA_out} !== {m_scl[n], m_sda[n]}) begin
                bad_n   = n;
                bad_got = {SCL_out, SDA_out};
                bad_exp = {m_scl[n], m_sda[n]};
            end
            if (done === 1'b1) got = n;
            else if (cmd_ready !== 1'b0 && busy_n == 0) busy_n = n;
        end
        cmd_valid = 1'b0;
        slave_sda = 1'b1;
        slave_scl = 1'b1;
        chk("done_cycle", id, 32'(got), 32'(exp_len));
        chk("ready_while_busy_cycle", id, 32'(busy_n), 32'd0);
        checks++;
        if (bad_n != 0) begin
            errors++;
            $display("FAIL lines #%0d: cycle %0d SCL,SDA got %b expected %b", id, bad_n, bad_got, bad_exp);
        end
        if (got != 0) begin
            chk("ready_at_done", id, 32'(cmd_ready), 32'd1);
            chk("arb_lost", id, 32'(arb_lost), 32'(exp_arb));
            chk("rdata", id, 32'(rdata), 32'(exp_rdata));
            if (op == 2'd2 && !exp_arb) chk("ack_rx", id, 32'(ack_rx), 32'(exp_ack));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] op;
        logic [7:0] wd, sb;
        logic       nack, sack;
        int         ext_q, dn;

        tbl[0] = '{2'd0, 8'h00, 1'b0, 8'h00, 1'b1, -1, LAT_SS,   8'h00, 1'b1, 1'b0};
        tbl[1] = '{2'd2, 8'hA5, 1'b0, 8'h00, 1'b0, -1, LAT_WR,   8'h00, 1'b0, 1'b0};
        tbl[2] = '{2'd3, 8'h00, 1'b1, 8'h3C, 1'b1, -1, LAT_WR,   8'h3C, 1'b0, 1'b0};
        tbl[3] = '{2'd2, 8'h00, 1'b0, 8'h00, 1'b1, -1, LAT_WR,   8'h00, 1'b1, 1'b0};
        tbl[4] = '{2'd3, 8'h00, 1'b0, 8'hA1, 1'b1, -1, LAT_WR,   8'hA1, 1'b0, 1'b0};
        tbl[5] = '{2'd2, 8'hFF, 1'b0, 8'h00, 1'b1, 10, LAT_ARBW, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{2'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1,  LAT_ARBS, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{2'd1, 8'h00, 1'b0, 8'h00, 1'b1, -1, LAT_SS,   8'h00, 1'b0, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_wdata = 8'h00;
        cmd_nack  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_scl", 0, 32'(SCL_out), 32'd1);
        chk("reset_sda", 0, 32'(SDA_out), 32'd1);
        chk("reset_ready", 0, 32'(cmd_ready), 32'd1);
        chk("reset_done", 0, 32'(done), 32'd0);
        chk("reset_rdata", 0, 32'(rdata), 32'd0);
        chk("reset_ack_rx", 0, 32'(ack_rx), 32'd1);
        chk("reset_arb", 0, 32'(arb_lost), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            build_model(tbl[i].op, tbl[i].wd, tbl[i].nack, tbl[i].sb, tbl[i].sack, tbl[i].ext_q, 0);
            run_cmd(i, tbl[i].op, tbl[i].wd, tbl[i].nack, tbl[i].exp_len,
                    tbl[i].exp_rdata, tbl[i].exp_ack, tbl[i].exp_arb);
        end

        for (int i = 0; i < 20; i++) begin
            op    = 2'($urandom_range(0, 3));
            wd    = 8'($urandom);
            sb    = 8'($urandom);
            nack  = 1'($urandom_range(0, 1));
            sack  = 1'($urandom_range(0, 1));
            ext_q = (op == 2'd2 && $urandom_range(0, 2) == 0) ? 4 * $urandom_range(0, 7) + 2 : -1;
            build_model(op, wd, nack, sb, sack, ext_q, 0);
            run_cmd(100 + i, op, wd, nack, m_len, (op == 2'd3) ? sb : 8'h00, sack, m_arb);
        end

        // Reset in the middle of WRITE bit 4.
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_wdata = 8'hC3;
        cmd_nack  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (16 * K + 4 * SX + 2) @(negedge clk);
        chk("mid_write_scl_low", 200, 32'(SCL_out), 32'd0);
        chk("mid_write_busy", 200, 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_scl", 200, 32'(SCL_out), 32'd1);
        chk("rst_mid_sda", 200, 32'(SDA_out), 32'd1);
        chk("rst_mid_ready", 200, 32'(cmd_ready), 32'd1);
        chk("rst_mid_rdata", 200, 32'(rdata), 32'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("rst_mid_no_done", 200, 32'(dn), 32'd0);
        build_model(2'd0, 8'h00, 1'b0, 8'h00, 1'b1, -1, 0);
        run_cmd(201, 2'd0, 8'h00, 1'b0, LAT_SS, 8'h00, 1'b0, 1'b0);

`ifdef I2C_CLK_STRETCH_EN
        build_model(2'd2, 8'h5A, 1'b0, 8'h00, 1'b0, -1, 0);
        run_cmd(300, 2'd2, 8'h5A, 1'b0, LAT_WR, 8'h00, 1'b0, 1'b0);
        build_model(2'd2, 8'h5A, 1'b0, 8'h00, 1'b0, -1, 20);
        run_cmd(301, 2'd2, 8'h5A, 1'b0, LAT_WR + 20, 8'h00, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
